seq_signed_divider: RTL and testbench



---
 rtl/seq_signed_divider_pkg.sv | 6 +
 rtl/seq_signed_divider_nr_div_step.sv | 22 ++
 rtl/seq_signed_divider.sv | 103 ++++++++++
 tb/tb_seq_signed_divider.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/seq_signed_divider_pkg.sv
// seq_signed_divider_pkg: shared state encoding and constants for the sequential divider
package seq_signed_divider_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, ITER, CORRECT, SIGN, DONE} div_state_t;
  localparam int div_width = 8;
  localparam logic [div_width-1:0] neg_max = {1'b1, {(div_width-1){1'b0}}};
endpackage

// File: rtl/seq_signed_divider_nr_div_step.sv
// nr_div_step: one (WIDTH+1)-bit add/subtract row of full-adder cells for non-restoring division
module nr_div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   p,
  input  logic [WIDTH-1:0] d,
  input  logic             sub,
  output logic [WIDTH:0]   p_new,
  output logic             q_bit
);
  logic [WIDTH:0] b;
  logic [WIDTH:0] c;
  assign b = {1'b0, d} ^ {(WIDTH+1){sub}};
  assign c[0] = sub;
  for (genvar i = 0; i <= WIDTH; i++) begin : g_sum
    assign p_new[i] = p[i] ^ b[i] ^ c[i];
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_carry
    assign c[i+1] = (p[i] & b[i]) | (c[i] & (p[i] ^ b[i]));
  end
  assign q_bit = ~p_new[WIDTH];
endmodule

// File: rtl/seq_signed_divider.sv
// seq_signed_divider: one-bit-per-cycle non-restoring signed divider with valid/ready handshakes
module seq_signed_divider
  import seq_signed_divider_pkg::*;
#(
  parameter int WIDTH = div_width
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);
  localparam int cw = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] neg_max_w = {1'b1, {(WIDTH-1){1'b0}}};
  div_state_t state;
  logic [cw-1:0] count;
  logic [WIDTH:0] p, p_sh, step_p, p_new;
  logic [WIDTH-1:0] q, d, a, b;
  logic q_bit, step_sub;
  assign p_sh = {p[WIDTH-1:0], q[WIDTH-1]};
  // the correction add reuses the row with sub forced low
  always_comb begin
    step_p = (state == ITER) ? p_sh : p;
    step_sub = (state == ITER) && !p_sh[WIDTH];
  end
  nr_div_step #(.WIDTH(WIDTH)) u_step (
    .p(step_p),
    .d(d),
    .sub(step_sub),
    .p_new(p_new),
    .q_bit(q_bit)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      in_ready <= 1'b0;
      out_valid <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
      overflow <= 1'b0;
      count <= '0;
      p <= '0;
      q <= '0;
      d <= '0;
      a <= '0;
      b <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a <= dividend;
            b <= divisor;
            in_ready <= 1'b0;
            div_by_zero <= 1'b0;
            overflow <= 1'b0;
            state <= LOAD;
          end else in_ready <= 1'b1;
        end
        LOAD: begin
          q <= a[WIDTH-1] ? -a : a;
          d <= b[WIDTH-1] ? -b : b;
          p <= '0;
          count <= cw'(WIDTH-1);
          div_by_zero <= (b == '0);
          state <= (b == '0) ? SIGN : ITER;
        end
        ITER: begin
          p <= p_new;
          q <= {q[WIDTH-2:0], q_bit};
          count <= count - 1'b1;
          if (count == '0) state <= CORRECT;
        end
        CORRECT: begin
          if (p[WIDTH]) p <= p_new;
          state <= SIGN;
        end
        SIGN: begin
          quotient <= div_by_zero ? '1 : (a[WIDTH-1] ^ b[WIDTH-1]) ? -q : q;
          remainder <= div_by_zero ? a : a[WIDTH-1] ? -p[WIDTH-1:0] : p[WIDTH-1:0];
          overflow <= (a == neg_max_w) && (b == '1);
          out_valid <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_signed_divider.sv
// tb_seq_signed_divider: directed and random checks of the sequential signed divider
module tb_seq_signed_divider;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] dividend = '0, divisor = '0;
  logic in_ready, out_valid, div_by_zero, overflow;
  logic [7:0] quotient, remainder;
  int passed = 0, total = 0, lat;
  logic stable;

  seq_signed_divider #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic issue(input logic [7:0] x, input logic [7:0] y);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    dividend = x;
    divisor = y;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    dividend = 8'($urandom);
    divisor = 8'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic [7:0] x, input logic [7:0] y,
                     input logic [7:0] eq, input logic [7:0] er, input logic edz,
                     input logic eov, input int elat);
    issue(x, y);
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    chk({tag, "_dz"}, div_by_zero, edz);
    chk({tag, "_ov"}, overflow, eov);
    consume();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_flags", {div_by_zero, overflow}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    run("p100_p7", 8'd100, 8'd7, 8'h0E, 8'h02, 0, 0, 11);
    run("n100_p7", 8'h9C, 8'd7, 8'hF2, 8'hFE, 0, 0, 11);
    run("p100_n7", 8'd100, 8'hF9, 8'hF2, 8'h02, 0, 0, 11);
    run("n100_n7", 8'h9C, 8'hF9, 8'h0E, 8'hFE, 0, 0, 11);
    run("min_neg1", 8'h80, 8'hFF, 8'h80, 8'h00, 0, 1, 11);
    run("min_p1", 8'h80, 8'h01, 8'h80, 8'h00, 0, 0, 11);
    run("div0", 8'd5, 8'd0, 8'hFF, 8'h05, 1, 0, 2);
    run("max_min", 8'h7F, 8'h80, 8'h00, 8'h7F, 0, 0, 11);
    run("min_min", 8'h80, 8'h80, 8'h01, 8'h00, 0, 0, 11);
    run("zero_p5", 8'h00, 8'd5, 8'h00, 8'h00, 0, 0, 11);

    issue(8'd100, 8'd7);
    chk("bp_lat", lat, 11);
    stable = 1'b1;
    repeat (20) begin
      in_valid = 1'b1;
      dividend = 8'd3;
      divisor = 8'd1;
      @(negedge clk);
      stable &= (quotient == 8'h0E) && (remainder == 8'h02) && out_valid && !in_ready;
    end
    in_valid = 1'b0;
    chk("bp_stable", stable, 1);
    consume();
    chk("bp_in_ready", in_ready, 1);
    chk("bp_out_valid", out_valid, 0);

    dividend = 8'd100;
    divisor = 8'd7;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_outs", {out_valid, div_by_zero, overflow, quotient, remainder}, 0);
    stable = 1'b1;
    repeat (15) begin
      @(negedge clk);
      stable &= !out_valid;
    end
    chk("mid_rst_no_result", stable, 1);
    run("p9_p3", 8'd9, 8'd3, 8'd3, 8'd0, 0, 0, 11);

    for (int i = 0; i < 300; i++) begin
      logic [7:0] x, y, eq, er;
      int sx, sy;
      x = 8'($urandom);
      y = (i % 50 == 0) ? 8'd0 : 8'($urandom);
      sx = int'($signed(x));
      sy = int'($signed(y));
      if (y == 8'd0) begin
        eq = 8'hFF;
        er = x;
      end else if (x == 8'h80 && y == 8'hFF) begin
        eq = 8'h80;
        er = 8'h00;
      end else begin
        eq = 8'(sx / sy);
        er = 8'(sx % sy);
      end
      run("rand", x, y, eq, er, y == 8'd0, x == 8'h80 && y == 8'hFF, (y == 8'd0) ? 2 : 11);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
